load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller that drives the 16x8 data memory on behalf of the CPU control path. Accepts one load or store request at a time and sequences the memory's read/write strobes. Detects write completion from the memory's toggling `done` line and captures read data after a fixed latency. Returns a one-cycle `ack` with read data or an error flag to the CPU. Sits between the control unit and the data memory block.

## Interface
- `RD_LAT`, 2: cycles `mem_r` is held before `mem_rdata` is captured (legal 1..15).
- `TIMEOUT`, 8: cycles allowed in a write without a `done` toggle before `err` (legal 1..255).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: CPU request strobe; sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load; sampled with `req`.
- `addr` in 4: word address; sampled with `req`.
- `wdata` in 8: store data; sampled with `req`.
- `busy` out 1: high in every state except IDLE.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 8: load result; valid when `ack`=1 and `err`=0, held until the next load completes.
- `err` out 1: valid only with `ack`; 1 = write timed out.
- `mem_addr` out 4: address to the memory; holds the latched request address.
- `mem_r` out 1: read strobe to the memory.
- `mem_w` out 1: write strobe to the memory.
- `mem_wdata` out 8: write data to the memory; holds the latched `wdata`.
- `mem_rdata` in 8: read data from the memory.
- `mem_done` in 1: write-completion line; each completed write inverts it.

## Operation
- All outputs are registered.
- Reset values: `busy` 0, `ack` 0, `err` 0, `rdata` 0x00, `mem_addr` 0, `mem_wdata` 0x00, `mem_r` 0, `mem_w` 0, state IDLE, counter 0.
- States: IDLE, WR_WAIT, RD_WAIT, RESP.
- IDLE, `req`=1:
  - Latch `addr` into `mem_addr` and `wdata` into `mem_wdata`.
  - Store `mem_done` in `done_ref`, clear the counter and `err`.
  - `we`=1: go to WR_WAIT with `mem_w`=1. `we`=0: go to RD_WAIT with `mem_r`=1.
- WR_WAIT, each edge:
  - `mem_done` != `done_ref`: `mem_w`=0, go to RESP.
  - Else, counter == TIMEOUT-1: `mem_w`=0, `err`=1, go to RESP.
  - Else: counter+1.
  - A toggle and the timeout on the same edge resolve as success (`err`=0).
- RD_WAIT, each edge:
  - Counter == RD_LAT-1: `rdata` <= `mem_rdata`, `mem_r`=0, go to RESP.
  - Else: counter+1.
- RESP: `ack`=1 for exactly one cycle, then IDLE.
- `req` is ignored outside IDLE; requests are never queued.
- `mem_r` and `mem_w` are never high together.
- `rdata` is unchanged by stores and by timed-out operations.
- Counter is 8 bits and never wraps: it saturates by construction at TIMEOUT-1 or RD_LAT-1.
- `rst` mid-operation: next edge returns to IDLE and drops both strobes; no `ack` is issued for the aborted request.

## Timing
- Let E0 be the edge that samples `req`=1 in IDLE.
- Load: `mem_r` is high for cycles E0+1 .. E0+RD_LAT. `rdata` is captured at edge E0+RD_LAT. `ack` is high in the cycle after that edge. With RD_LAT=2, `ack` is in the 3rd cycle after E0.
- Store: `mem_w` rises after E0. A toggle first seen at edge En drops `mem_w` after En, and `ack` is high in the following cycle. Minimum store: toggle seen at E0+1, `ack` in cycle E0+2.
- Timeout: with no toggle, `mem_w` drops after edge E0+TIMEOUT, and `ack`=1 with `err`=1 in the next cycle.
- `busy` is high from the cycle after E0 through the RESP cycle. The next `req` is accepted at the edge ending RESP+1 (back in IDLE).
- Toggle detection compares against `done_ref`. Either polarity of `mem_done` at launch is legal. A toggle that occurs while in IDLE is ignored.

## Test plan
- Reset with all inputs X-free: every output reads 0 after one `rst` edge; `busy`=0.
- Store `addr`=3, `wdata`=0xA5, model toggles `mem_done` 2 cycles after `mem_w` rises: `mem_addr`=3, `mem_wdata`=0xA5, `mem_w` high 2 cycles, `ack`=1 and `err`=0 for one cycle, `rdata` unchanged.
- Load `addr`=1, model returns 0x0F, RD_LAT=2: `mem_r` high exactly 2 cycles, `rdata`=0x0F with `ack`, `mem_w` never asserted.
- Store with no toggle, TIMEOUT=8: `mem_w` high 8 cycles, `ack`=1 and `err`=1, then the following load `addr`=3 completes normally with `err`=0.
- Back-to-back `req` held high across a store then a load, with `mem_done` starting at 1: second request is accepted only in IDLE after RESP; the store completes on the toggle 1→0; no overlapping strobes.
- `rst` asserted during RD_WAIT: strobes drop on the next edge, no `ack`, `rdata` returns to 0x00.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store sequencer between the CPU control path and the 16x8 data memory.
// One request in flight: reads complete after a fixed latency, writes complete on a done-line toggle.
module load_store_unit #(
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       ack,
   output logic [7:0] rdata,
   output logic       err,
   output logic [3:0] mem_addr,
   output logic       mem_r,
   output logic       mem_w,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   input  logic       mem_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state_r, state_s;
   logic [7:0] cnt_r, cnt_s;
   logic       done_ref_r, done_ref_s;
   logic       busy_s, ack_s, err_s, mem_r_s, mem_w_s;
   logic [7:0] rdata_s, mem_wdata_s;
   logic [3:0] mem_addr_s;

   // Next-state and next-output computation; every output is then registered.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      done_ref_s  = done_ref_r;
      err_s       = err;
      rdata_s     = rdata;
      mem_addr_s  = mem_addr;
      mem_wdata_s = mem_wdata;
      mem_r_s     = mem_r;
      mem_w_s     = mem_w;
      case (state_r)
         IDLE: begin
            if (req) begin
               mem_addr_s  = addr;
               mem_wdata_s = wdata;
               done_ref_s  = mem_done;
               cnt_s       = 8'd0;
               err_s       = 1'b0;
               if (we) begin
                  mem_w_s = 1'b1;
                  state_s = WR_WAIT;
               end else begin
                  mem_r_s = 1'b1;
                  state_s = RD_WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         // A toggle seen on the timeout edge still counts as success.
         WR_WAIT: begin
            if (mem_done != done_ref_r) begin
               mem_w_s = 1'b0;
               state_s = RESP;
            end else if (cnt_r == TO_LAST) begin
               mem_w_s = 1'b0;
               err_s   = 1'b1;
               state_s = RESP;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         RD_WAIT: begin
            if (cnt_r == RD_LAST) begin
               rdata_s = mem_rdata;
               mem_r_s = 1'b0;
               state_s = RESP;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            mem_r_s = 1'b0;
            mem_w_s = 1'b0;
         end
      endcase
      busy_s = (state_s != IDLE);
      ack_s  = (state_s == RESP);
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         done_ref_r <= 1'b0;
         busy       <= 1'b0;
         ack        <= 1'b0;
         err        <= 1'b0;
         rdata      <= 8'h00;
         mem_addr   <= 4'd0;
         mem_wdata  <= 8'h00;
         mem_r      <= 1'b0;
         mem_w      <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         done_ref_r <= done_ref_s;
         busy       <= busy_s;
         ack        <= ack_s;
         err        <= err_s;
         rdata      <= rdata_s;
         mem_addr   <= mem_addr_s;
         mem_wdata  <= mem_wdata_s;
         mem_r      <= mem_r_s;
         mem_w      <= mem_w_s;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a transaction-level reference model.
// The bench plays the data memory: a 16x8 array plus a done line toggled on write completion.
module tb_load_store_unit;

   localparam int RD_LAT  = 2;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst, req, we;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic       busy, ack, err, mem_r, mem_w, mem_done;
   logic [7:0] rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_addr;

   logic [7:0] mem_arr [16];
   logic [7:0] ref_mem [16];
   logic [7:0] model_rdata;
   int         errors = 0;
   int         checks = 0;

   load_store_unit #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .ack(ack), .rdata(rdata), .err(err),
      .mem_addr(mem_addr), .mem_r(mem_r), .mem_w(mem_w), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   assign mem_rdata = mem_arr[mem_addr];

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One request issued from IDLE at a negedge; dly = cycle in which the memory toggles done (0 = never).
   task automatic run_txn(input logic w, input logic [3:0] a, input logic [7:0] d, input int dly);
      int         ack_k, strobe_n, exp_k, exp_strobe;
      logic       ack_err, exp_err, bad_strobe, busy_ok;
      logic [7:0] ack_rdata, exp_rdata;
      bit         completes;
      completes = w && dly >= 1 && dly <= TIMEOUT;
      if (w) begin
         exp_k      = completes ? dly + 1 : TIMEOUT + 1;
         exp_strobe = completes ? dly : TIMEOUT;
         exp_err    = !completes;
         exp_rdata  = model_rdata;
      end else begin
         exp_k      = RD_LAT + 1;
         exp_strobe = RD_LAT;
         exp_err    = 1'b0;
         exp_rdata  = ref_mem[a];
      end
      ack_k = 0; strobe_n = 0; bad_strobe = 1'b0; busy_ok = 1'b1;
      ack_err = 1'b0; ack_rdata = 8'h00;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk);
      @(negedge clk);
      for (int k = 1; k <= 40 && ack_k == 0; k++) begin
         if (k == 1) begin
            check_eq("mem_addr", mem_addr, a);
            check_eq("mem_wdata", mem_wdata, d);
         end
         if (mem_r && mem_w) bad_strobe = 1'b1;
         if (w ? mem_r : mem_w) bad_strobe = 1'b1;
         if (w ? mem_w : mem_r) strobe_n++;
         if (!busy) busy_ok = 1'b0;
         if (ack) begin
            ack_k = k; ack_err = err; ack_rdata = rdata;
            req = 1'b0;
         end else begin
            if (completes && k == dly) begin
               mem_arr[mem_addr] = mem_wdata;
               mem_done = ~mem_done;
            end
            req = 1'($urandom_range(0, 1)); we = 1'($urandom);
            addr = 4'($urandom); wdata = 8'($urandom);
            @(negedge clk);
         end
      end
      check_eq("ack_cycle", ack_k, exp_k);
      check_eq("strobe_cycles", strobe_n, exp_strobe);
      check_eq("strobe_overlap", bad_strobe, 1'b0);
      check_eq("busy_in_txn", busy_ok, 1'b1);
      if (ack_k != 0) begin
         check_eq("err", ack_err, exp_err);
         check_eq("rdata", ack_rdata, exp_rdata);
         @(negedge clk);
         check_eq("ack_one_cycle", ack, 1'b0);
         check_eq("busy_idle", busy, 1'b0);
      end
      if (completes) ref_mem[a] = d;
      if (!w) model_rdata = exp_rdata;
   endtask

   logic       saw_ack, bb_overlap, bb_busy4, bb_st_err;
   int         bb_first_r, bb_st_ack, bb_ld_ack;
   logic [7:0] bb_ld_rdata;

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 8'h00; mem_done = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_arr[i] = 8'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[1] = 8'h0F; ref_mem[1] = 8'h0F;
      model_rdata = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_ack", ack, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_rdata", rdata, 8'h00);
      check_eq("rst_mem_addr", mem_addr, 4'd0);
      check_eq("rst_mem_wdata", mem_wdata, 8'h00);
      check_eq("rst_mem_r", mem_r, 1'b0);
      check_eq("rst_mem_w", mem_w, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(1'b1, 4'd3, 8'hA5, 2);
      run_txn(1'b0, 4'd1, 8'h00, 0);
      run_txn(1'b1, 4'd7, 8'h5A, 0);
      run_txn(1'b0, 4'd3, 8'h00, 0);
      run_txn(1'b1, 4'd9, 8'hC3, 1);
      run_txn(1'b1, 4'd10, 8'h96, TIMEOUT);
      run_txn(1'b0, 4'd10, 8'h00, 0);

      // Abort a load in RD_WAIT.
      req = 1'b1; we = 1'b0; addr = 4'd2; wdata = 8'h00;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check_eq("abort_pre_mem_r", mem_r, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_mem_r", mem_r, 1'b0);
      check_eq("abort_mem_w", mem_w, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_ack", ack, 1'b0);
      check_eq("abort_rdata", rdata, 8'h00);
      rst = 1'b0;
      saw_ack = 1'b0;
      repeat (RD_LAT + 3) begin
         @(negedge clk);
         if (ack) saw_ack = 1'b1;
      end
      check_eq("abort_no_ack", saw_ack, 1'b0);
      model_rdata = 8'h00;

      // Back-to-back: req held high across a store then a load, done starting at 1.
      mem_done = 1'b1;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      bb_first_r = 0; bb_st_ack = 0; bb_ld_ack = 0; bb_overlap = 1'b0;
      bb_busy4 = 1'b1; bb_st_err = 1'b1; bb_ld_rdata = 8'h00;
      for (int k = 1; k <= 20; k++) begin
         if (k == 1) we = 1'b0;
         if (mem_r && mem_w) bb_overlap = 1'b1;
         if (mem_r && bb_first_r == 0) bb_first_r = k;
         if (k == 4) bb_busy4 = busy;
         if (ack && bb_st_ack == 0) begin
            bb_st_ack = k; bb_st_err = err;
         end else if (ack && bb_ld_ack == 0) begin
            bb_ld_ack = k; bb_ld_rdata = rdata; req = 1'b0;
         end
         if (k == 2) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_done = 1'b0;
         end
         @(negedge clk);
      end
      check_eq("b2b_store_ack", bb_st_ack, 3);
      check_eq("b2b_store_err", bb_st_err, 1'b0);
      check_eq("b2b_idle_gap", bb_busy4, 1'b0);
      check_eq("b2b_load_start", bb_first_r, 5);
      check_eq("b2b_load_ack", bb_ld_ack, 5 + RD_LAT);
      check_eq("b2b_load_rdata", bb_ld_rdata, 8'h3C);
      check_eq("b2b_overlap", bb_overlap, 1'b0);
      ref_mem[5] = 8'h3C;
      model_rdata = 8'h3C;

      for (int n = 0; n < 60; n++) begin
         logic w;
         int   dly;
         w   = 1'($urandom_range(0, 1));
         dly = w ? $urandom_range(0, TIMEOUT) : 0;
         repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 1) mem_done = ~mem_done;
            @(negedge clk);
         end
         run_txn(w, 4'($urandom), 8'($urandom), dly);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
